// File: rtl/wb_port_arbiter_pkg.sv
// Shared constants and the md/fp round-robin pick used by the write-port arbiter.
// Request indices select bits of the internal one-hot grant vector.
package wb_port_arbiter_pkg;

  localparam int NUM_REQ = 3;
  localparam int REQ_ALU = 0;
  localparam int REQ_MD  = 1;
  localparam int REQ_FP  = 2;

  localparam int RF_AW  = 5;
  localparam int WAIT_W = 4;

  typedef logic [RF_AW-1:0] reg_idx_t;

  localparam reg_idx_t X0 = 5'd0;

  // Returns {fp_gnt, md_gnt}; rr=0 favours md, rr=1 favours fp.
  function automatic logic [1:0] rr_pick(input logic md_req,
                                         input logic fp_req,
                                         input logic rr);
    logic [1:0] pick;
    pick = 2'b00;
    if (md_req && fp_req) begin
      pick = rr ? 2'b10 : 2'b01;
    end else if (md_req) begin
      pick = 2'b01;
    end else if (fp_req) begin
      pick = 2'b10;
    end
    return pick;
  endfunction

endpackage

// File: rtl/wb_busy_board.sv
// Busy scoreboard for destinations of in-flight multi-cycle ops.
// Supplies issue_ok and the two read-port hazard flags from the registered bits.
module wb_busy_board
  import wb_port_arbiter_pkg::*;
(
  input  logic     clk,
  input  logic     clr,
  input  logic     issue_valid,
  input  reg_idx_t issue_rd,
  output logic     issue_ok,
  input  logic     wb_clr_valid,
  input  reg_idx_t wb_clr_rd,
  input  reg_idx_t rna,
  input  reg_idx_t rnb,
  output logic     hazard_a,
  output logic     hazard_b
);

  // Bit 0 exists only so every 5-bit index is in range; it is pinned to 0.
  logic [31:0] busy_q;
  logic [31:0] busy_d;
  logic        set_en;

  always_comb begin
    issue_ok = (issue_rd == X0) || !busy_q[issue_rd];
    set_en   = issue_valid && issue_ok && (issue_rd != X0);
    hazard_a = busy_q[rna] && (rna != X0);
    hazard_b = busy_q[rnb] && (rnb != X0);
  end

  // Clear is applied before set so a same-edge set on the same register wins.
  always_comb begin
    busy_d = busy_q;
    if (wb_clr_valid) begin
      busy_d[wb_clr_rd] = 1'b0;
    end
    if (set_en) begin
      busy_d[issue_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Arbitrates ALU, mul/div and FPU-int results onto the single regfile write port,
// with anti-starvation aging for md/fp and a registered write stage.
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int DW       = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          alu_valid,
  input  logic [4:0]    alu_rd,
  input  logic [DW-1:0] alu_d,
  output logic          alu_ready,
  input  logic          md_valid,
  input  logic [4:0]    md_rd,
  input  logic [DW-1:0] md_d,
  output logic          md_ready,
  input  logic          fp_valid,
  input  logic [4:0]    fp_rd,
  input  logic [DW-1:0] fp_d,
  output logic          fp_ready,
  input  logic          issue_valid,
  input  logic [4:0]    issue_rd,
  output logic          issue_ok,
  input  logic [4:0]    rna,
  input  logic [4:0]    rnb,
  output logic          hazard_a,
  output logic          hazard_b,
  output logic [4:0]    wb_wn,
  output logic [DW-1:0] wb_d,
  output logic          wb_we
);

  // Handshake: a result moves on a cycle with valid && ready; the producer holds
  // valid/rd/d until then. ready is a function of internal state and the valid
  // inputs only, and is forced low while clr is high.

  localparam logic [WAIT_W-1:0] MAX_WAIT_C = WAIT_W'(MAX_WAIT);

  logic [NUM_REQ-1:0] gnt;
  logic               md_aged;
  logic               fp_aged;

  logic               rr_q, rr_d;
  logic [WAIT_W-1:0]  md_wait_q, md_wait_d;
  logic [WAIT_W-1:0]  fp_wait_q, fp_wait_d;

  logic               wb_we_q, wb_we_d;
  logic [4:0]         wb_wn_q, wb_wn_d;
  logic [DW-1:0]      wb_d_q, wb_d_d;

  logic               busy_clr_valid;
  reg_idx_t           busy_clr_rd;

  // Grant select: aged md/fp first, then ALU, then md/fp by round robin.
  always_comb begin
    gnt     = '0;
    md_aged = md_valid && (md_wait_q == MAX_WAIT_C);
    fp_aged = fp_valid && (fp_wait_q == MAX_WAIT_C);
    if (!clr) begin
      if (md_aged || fp_aged) begin
        {gnt[REQ_FP], gnt[REQ_MD]} = rr_pick(md_aged, fp_aged, rr_q);
      end else if (alu_valid) begin
        gnt[REQ_ALU] = 1'b1;
      end else begin
        {gnt[REQ_FP], gnt[REQ_MD]} = rr_pick(md_valid, fp_valid, rr_q);
      end
    end
  end

  always_comb begin
    alu_ready = gnt[REQ_ALU];
    md_ready  = gnt[REQ_MD];
    fp_ready  = gnt[REQ_FP];
  end

  // rr points at the unit that did not just win; ALU grants leave it alone.
  always_comb begin
    rr_d = rr_q;
    if (gnt[REQ_MD]) begin
      rr_d = 1'b1;
    end else if (gnt[REQ_FP]) begin
      rr_d = 1'b0;
    end
  end

  always_comb begin
    md_wait_d = md_wait_q;
    if (!md_valid || gnt[REQ_MD]) begin
      md_wait_d = '0;
    end else if (md_wait_q != MAX_WAIT_C) begin
      md_wait_d = md_wait_q + 1'b1;
    end

    fp_wait_d = fp_wait_q;
    if (!fp_valid || gnt[REQ_FP]) begin
      fp_wait_d = '0;
    end else if (fp_wait_q != MAX_WAIT_C) begin
      fp_wait_d = fp_wait_q + 1'b1;
    end
  end

  // Write stage: load the winner; with no grant only wb_we drops.
  always_comb begin
    wb_we_d = 1'b0;
    wb_wn_d = wb_wn_q;
    wb_d_d  = wb_d_q;
    if (gnt[REQ_ALU]) begin
      wb_wn_d = alu_rd;
      wb_d_d  = alu_d;
      wb_we_d = (alu_rd != X0);
    end else if (gnt[REQ_MD]) begin
      wb_wn_d = md_rd;
      wb_d_d  = md_d;
      wb_we_d = (md_rd != X0);
    end else if (gnt[REQ_FP]) begin
      wb_wn_d = fp_rd;
      wb_d_d  = fp_d;
      wb_we_d = (fp_rd != X0);
    end
  end

  always_comb begin
    busy_clr_valid = gnt[REQ_MD] || gnt[REQ_FP];
    busy_clr_rd    = gnt[REQ_MD] ? md_rd : fp_rd;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      rr_q      <= 1'b0;
      md_wait_q <= '0;
      fp_wait_q <= '0;
      wb_we_q   <= 1'b0;
      wb_wn_q   <= '0;
      wb_d_q    <= '0;
    end else begin
      rr_q      <= rr_d;
      md_wait_q <= md_wait_d;
      fp_wait_q <= fp_wait_d;
      wb_we_q   <= wb_we_d;
      wb_wn_q   <= wb_wn_d;
      wb_d_q    <= wb_d_d;
    end
  end

  always_comb begin
    wb_we = wb_we_q;
    wb_wn = wb_wn_q;
    wb_d  = wb_d_q;
  end

  wb_busy_board u_busy (
    .clk          (clk),
    .clr          (clr),
    .issue_valid  (issue_valid),
    .issue_rd     (issue_rd),
    .issue_ok     (issue_ok),
    .wb_clr_valid (busy_clr_valid),
    .wb_clr_rd    (busy_clr_rd),
    .rna          (rna),
    .rnb          (rnb),
    .hazard_a     (hazard_a),
    .hazard_b     (hazard_b)
  );

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: per-scenario tasks check ready/hazard inline,
// and a negedge monitor pops the expected write-port queue whenever wb_we is high.
module tb_wb_port_arbiter;

  localparam int DW = 32;
  localparam int EW = 5 + DW;

  logic          clk;
  logic          clr;
  logic          alu_valid, md_valid, fp_valid;
  logic [4:0]    alu_rd, md_rd, fp_rd;
  logic [DW-1:0] alu_d, md_d, fp_d;
  logic          alu_ready, md_ready, fp_ready;
  logic          issue_valid;
  logic [4:0]    issue_rd;
  logic          issue_ok;
  logic [4:0]    rna, rnb;
  logic          hazard_a, hazard_b;
  logic [4:0]    wb_wn;
  logic [DW-1:0] wb_d;
  logic          wb_we;

  logic [EW-1:0] exp_q[$];
  int            checks;
  int            errors;

  wb_port_arbiter #(.DW(DW), .MAX_WAIT(4)) dut (
    .clk         (clk),
    .clr         (clr),
    .alu_valid   (alu_valid),
    .alu_rd      (alu_rd),
    .alu_d       (alu_d),
    .alu_ready   (alu_ready),
    .md_valid    (md_valid),
    .md_rd       (md_rd),
    .md_d        (md_d),
    .md_ready    (md_ready),
    .fp_valid    (fp_valid),
    .fp_rd       (fp_rd),
    .fp_d        (fp_d),
    .fp_ready    (fp_ready),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .issue_ok    (issue_ok),
    .rna         (rna),
    .rnb         (rnb),
    .hazard_a    (hazard_a),
    .hazard_b    (hazard_b),
    .wb_wn       (wb_wn),
    .wb_d        (wb_d),
    .wb_we       (wb_we)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard: every registered write must match the oldest expected entry
  always @(negedge clk) begin
    if (clr === 1'b0 && wb_we !== 1'b0) begin
      logic [EW-1:0] exp_e;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL wb_unexpected: got wb_we=%b wn=%0d d=%h, expected no write", wb_we, wb_wn, wb_d);
      end else begin
        exp_e = exp_q.pop_front();
        if (wb_we !== 1'b1 || {wb_wn, wb_d} !== exp_e) begin
          errors++;
          $display("FAIL wb_write: got we=%b wn=%0d d=%h, expected we=1 wn=%0d d=%h",
                   wb_we, wb_wn, wb_d, exp_e[EW-1 -: 5], exp_e[DW-1:0]);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alu_valid = 1'b0; md_valid = 1'b0; fp_valid = 1'b0;
    issue_valid = 1'b0;
  endtask

  task automatic test_reset();
    clr = 1'b1;
    alu_valid = 1'b1; alu_rd = 5'd1; alu_d = 32'h1111_1111;
    md_valid  = 1'b1; md_rd  = 5'd2; md_d  = 32'h2222_2222;
    fp_valid  = 1'b1; fp_rd  = 5'd3; fp_d  = 32'h3333_3333;
    issue_valid = 1'b0; issue_rd = 5'd0;
    rna = 5'd5; rnb = 5'd6;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if ({alu_ready, md_ready, fp_ready} !== 3'b000) begin
        errors++;
        $display("FAIL reset_ready: got %b expected 000", {alu_ready, md_ready, fp_ready});
      end
      checks++;
      if (wb_we !== 1'b0 || wb_wn !== 5'd0 || wb_d !== 32'd0) begin
        errors++;
        $display("FAIL reset_wb: got we=%b wn=%0d d=%h expected 0/0/0", wb_we, wb_wn, wb_d);
      end
      checks++;
      if ({hazard_a, hazard_b} !== 2'b00) begin
        errors++;
        $display("FAIL reset_hazard: got %b expected 00", {hazard_a, hazard_b});
      end
    end
    step();
    clr = 1'b0;
    idle_inputs();
  endtask

  task automatic test_alu_single();
    alu_valid = 1'b1; alu_rd = 5'd5; alu_d = 32'hDEAD_BEEF;
    @(negedge clk);
    checks++;
    if ({alu_ready, md_ready, fp_ready} !== 3'b100) begin
      errors++;
      $display("FAIL alu_ready: got %b expected 100", {alu_ready, md_ready, fp_ready});
    end
    exp_q.push_back({5'd5, 32'hDEAD_BEEF});
    step();
    alu_valid = 1'b0;
    @(negedge clk);
    step();
    @(negedge clk);
    checks++;
    if (wb_we !== 1'b0 || wb_wn !== 5'd5 || wb_d !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL alu_hold: got we=%b wn=%0d d=%h expected 0/5/deadbeef", wb_we, wb_wn, wb_d);
    end
    step();
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_r[7];
    logic [4:0] exp_wn[7];
    exp_r  = '{3'b010, 3'b001, 3'b010, 3'b010, 3'b001, 3'b010, 3'b001};
    exp_wn = '{5'd10, 5'd11, 5'd12, 5'd16, 5'd14, 5'd13, 5'd15};
    md_valid = 1'b1; md_rd = 5'd10; md_d = 32'hA0A0_0010;
    fp_valid = 1'b1; fp_rd = 5'd11; fp_d = 32'hB0B0_0011;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      checks++;
      if ({alu_ready, md_ready, fp_ready} !== exp_r[i]) begin
        errors++;
        $display("FAIL rr_grant[%0d]: got %b expected %b", i, {alu_ready, md_ready, fp_ready}, exp_r[i]);
      end
      exp_q.push_back({exp_wn[i], (exp_r[i] == 3'b010) ? md_d : fp_d});
      step();
      case (i)
        0: md_valid = 1'b0;
        1: begin fp_valid = 1'b0; md_valid = 1'b1; md_rd = 5'd12; md_d = 32'hA0A0_0012; end
        2: begin md_rd = 5'd16; md_d = 32'hA0A0_0016; end
        3: begin md_rd = 5'd13; md_d = 32'hA0A0_0013;
                 fp_valid = 1'b1; fp_rd = 5'd14; fp_d = 32'hB0B0_0014; end
        4: fp_valid = 1'b0;
        5: begin md_valid = 1'b0; fp_valid = 1'b1; fp_rd = 5'd15; fp_d = 32'hB0B0_0015; end
        default: fp_valid = 1'b0;
      endcase
    end
    @(negedge clk);
    step();
  endtask

  task automatic test_aging();
    logic [2:0] exp_r[6];
    exp_r = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b010, 3'b100};
    md_valid = 1'b1; md_rd = 5'd20; md_d = 32'h0000_0D20;
    for (int i = 0; i < 6; i++) begin
      alu_valid = 1'b1;
      alu_rd = 5'($urandom_range(1, 31));
      alu_d  = $urandom;
      @(negedge clk);
      checks++;
      if ({alu_ready, md_ready, fp_ready} !== exp_r[i]) begin
        errors++;
        $display("FAIL aging_grant[%0d]: got %b expected %b", i, {alu_ready, md_ready, fp_ready}, exp_r[i]);
      end
      if (exp_r[i] == 3'b100) exp_q.push_back({alu_rd, alu_d});
      else                    exp_q.push_back({md_rd, md_d});
      step();
      if (i == 4) md_valid = 1'b0;
    end
    idle_inputs();
    @(negedge clk);
    step();
  endtask

  task automatic test_aging_both();
    logic [2:0] exp_r[7];
    exp_r = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b001, 3'b010, 3'b100};
    md_valid = 1'b1; md_rd = 5'd21; md_d = 32'h0000_0D21;
    fp_valid = 1'b1; fp_rd = 5'd22; fp_d = 32'h0000_0F22;
    for (int i = 0; i < 7; i++) begin
      alu_valid = 1'b1;
      alu_rd = 5'($urandom_range(1, 31));
      alu_d  = $urandom;
      @(negedge clk);
      checks++;
      if ({alu_ready, md_ready, fp_ready} !== exp_r[i]) begin
        errors++;
        $display("FAIL aging_both[%0d]: got %b expected %b", i, {alu_ready, md_ready, fp_ready}, exp_r[i]);
      end
      case (exp_r[i])
        3'b010:  exp_q.push_back({md_rd, md_d});
        3'b001:  exp_q.push_back({fp_rd, fp_d});
        default: exp_q.push_back({alu_rd, alu_d});
      endcase
      step();
      if (i == 4) fp_valid = 1'b0;
      if (i == 5) md_valid = 1'b0;
    end
    idle_inputs();
    @(negedge clk);
    step();
  endtask

  task automatic test_hazard();
    rna = 5'd7; rnb = 5'd3;
    issue_valid = 1'b1; issue_rd = 5'd7;
    @(negedge clk);
    checks++;
    if (issue_ok !== 1'b1 || hazard_a !== 1'b0) begin
      errors++;
      $display("FAIL hz_first_issue: got ok=%b hz_a=%b expected ok=1 hz_a=0", issue_ok, hazard_a);
    end
    step();
    @(negedge clk);
    checks++;
    if (issue_ok !== 1'b0 || hazard_a !== 1'b1 || hazard_b !== 1'b0) begin
      errors++;
      $display("FAIL hz_busy: got ok=%b hz_a=%b hz_b=%b expected 0/1/0", issue_ok, hazard_a, hazard_b);
    end
    step();
    issue_rd = 5'd0; rnb = 5'd0;
    @(negedge clk);
    checks++;
    if (issue_ok !== 1'b1 || hazard_b !== 1'b0) begin
      errors++;
      $display("FAIL hz_x0: got ok=%b hz_b=%b expected ok=1 hz_b=0", issue_ok, hazard_b);
    end
    step();
    issue_valid = 1'b0;
    md_valid = 1'b1; md_rd = 5'd7; md_d = 32'h0707_0707;
    @(negedge clk);
    checks++;
    if (md_ready !== 1'b1 || hazard_a !== 1'b1 || hazard_b !== 1'b0) begin
      errors++;
      $display("FAIL hz_no_bypass: got md_ready=%b hz_a=%b hz_b=%b expected 1/1/0", md_ready, hazard_a, hazard_b);
    end
    exp_q.push_back({5'd7, 32'h0707_0707});
    step();
    md_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (hazard_a !== 1'b0) begin
        errors++;
        $display("FAIL hz_cleared[%0d]: got hz_a=%b expected 0", i, hazard_a);
      end
      step();
    end
  endtask

  task automatic test_set_wins();
    rna = 5'd9;
    md_valid = 1'b1; md_rd = 5'd9; md_d = 32'h0909_0909;
    issue_valid = 1'b1; issue_rd = 5'd9;
    @(negedge clk);
    checks++;
    if (md_ready !== 1'b1 || issue_ok !== 1'b1 || hazard_a !== 1'b0) begin
      errors++;
      $display("FAIL sw_setup: got md_ready=%b ok=%b hz_a=%b expected 1/1/0", md_ready, issue_ok, hazard_a);
    end
    exp_q.push_back({5'd9, 32'h0909_0909});
    step();
    md_valid = 1'b0; issue_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (hazard_a !== 1'b1 || issue_ok !== 1'b0) begin
      errors++;
      $display("FAIL sw_set_wins: got hz_a=%b ok=%b expected hz_a=1 ok=0", hazard_a, issue_ok);
    end
    step();
    fp_valid = 1'b1; fp_rd = 5'd9; fp_d = 32'hF909_0909;
    @(negedge clk);
    checks++;
    if ({alu_ready, md_ready, fp_ready} !== 3'b001) begin
      errors++;
      $display("FAIL sw_fp_grant: got %b expected 001", {alu_ready, md_ready, fp_ready});
    end
    exp_q.push_back({5'd9, 32'hF909_0909});
    step();
    fp_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (hazard_a !== 1'b0) begin
      errors++;
      $display("FAIL sw_fp_clear: got hz_a=%b expected 0", hazard_a);
    end
    step();
  endtask

  task automatic test_alu_x0_and_no_clear();
    rna = 5'd12;
    issue_valid = 1'b1; issue_rd = 5'd12;
    step();
    issue_valid = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd12; alu_d = $urandom;
    @(negedge clk);
    checks++;
    if (alu_ready !== 1'b1) begin
      errors++;
      $display("FAIL alu_busy_grant: got alu_ready=%b expected 1", alu_ready);
    end
    exp_q.push_back({alu_rd, alu_d});
    step();
    alu_rd = 5'd0; alu_d = 32'h0000_0123;
    @(negedge clk);
    checks++;
    if (hazard_a !== 1'b1 || alu_ready !== 1'b1) begin
      errors++;
      $display("FAIL alu_no_clear: got hz_a=%b alu_ready=%b expected 1/1", hazard_a, alu_ready);
    end
    step();
    alu_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (wb_we !== 1'b0 || wb_wn !== 5'd0 || wb_d !== 32'h0000_0123) begin
      errors++;
      $display("FAIL alu_x0_write: got we=%b wn=%0d d=%h expected 0/0/123", wb_we, wb_wn, wb_d);
    end
    step();
    md_valid = 1'b1; md_rd = 5'd12; md_d = 32'h0C0C_0C0C;
    @(negedge clk);
    checks++;
    if (wb_we !== 1'b0 || wb_d !== 32'h0000_0123 || md_ready !== 1'b1) begin
      errors++;
      $display("FAIL idle_hold: got we=%b d=%h md_ready=%b expected 0/123/1", wb_we, wb_d, md_ready);
    end
    exp_q.push_back({5'd12, 32'h0C0C_0C0C});
    step();
    md_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (hazard_a !== 1'b0) begin
      errors++;
      $display("FAIL md_clear12: got hz_a=%b expected 0", hazard_a);
    end
    step();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 24; i++) begin
      alu_valid = 1'b1;
      alu_rd = 5'($urandom_range(0, 31));
      alu_d  = $urandom;
      @(negedge clk);
      checks++;
      if ({alu_ready, md_ready, fp_ready} !== 3'b100) begin
        errors++;
        $display("FAIL b2b_ready[%0d]: got %b expected 100", i, {alu_ready, md_ready, fp_ready});
      end
      if (alu_rd != 5'd0) exp_q.push_back({alu_rd, alu_d});
      step();
    end
    alu_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      step();
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_alu_single();
    test_round_robin();
    test_aging();
    test_aging_both();
    test_hazard();
    test_set_wins();
    test_alu_x0_and_no_clear();
    test_back_to_back();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL wb_drain: got %0d writes outstanding, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the single register-file write port (wn/d/we) among three result producers: the integer ALU, the multi-cycle mul/div unit, and the FPU integer-result path (fmv.x.w, fcvt.w.s, compares).
- Holds a 31-entry busy scoreboard for destinations of in-flight multi-cycle ops and flags read-port RAW/WAW hazards to the issue stage.
- Sits between the execute units and the regfile; its write outputs drive the regfile directly.

Parameters:
- DW, 32, data width of results and of the regfile write port.
- MAX_WAIT, 4, consecutive denied cycles after which a waiting mul/div or FPU request overrides the ALU; legal range 1..15.

Ports:
- clk  in  1  clock; every register updates on the rising edge.
- clr  in  1  reset, synchronous, active-high.
- alu_valid  in  1  ALU result valid.
- alu_rd  in  5  ALU destination register.
- alu_d  in  DW  ALU result.
- alu_ready  out  1  ALU result accepted this cycle (combinational).
- md_valid  in  1  mul/div result valid.
- md_rd  in  5  mul/div destination register.
- md_d  in  DW  mul/div result.
- md_ready  out  1  mul/div result accepted (combinational).
- fp_valid  in  1  FPU integer result valid.
- fp_rd  in  5  FPU destination register.
- fp_d  in  DW  FPU result.
- fp_ready  out  1  FPU result accepted (combinational).
- issue_valid  in  1  a multi-cycle op (mul/div or FPU-to-int) issues this cycle.
- issue_rd  in  5  destination register of the issuing op.
- issue_ok  out  1  issue permitted: issue_rd is not busy, or issue_rd==0.
- rna  in  5  register number on read port A.
- rnb  in  5  register number on read port B.
- hazard_a  out  1  busy[rna] && rna!=0.
- hazard_b  out  1  busy[rnb] && rnb!=0.
- wb_wn  out  5  regfile write register number (registered).
- wb_d  out  DW  regfile write data (registered).
- wb_we  out  1  regfile write enable (registered).

Behaviour:
- Handshake: a transfer occurs on a cycle where valid && ready. A producer holds valid, rd and d stable until accepted. ready depends only on internal state and the current valid inputs, never on the producer's own data.
- At most one grant per cycle. Grant priority, highest first:
  1. Any aged request (wait counter == MAX_WAIT). If both md and fp are aged, the round-robin pointer decides.
  2. ALU.
  3. md vs fp by the round-robin pointer rr: rr=0 prefers md, rr=1 prefers fp.
- rr flips to point at the other unit after any md or fp grant; an ALU grant leaves rr unchanged.
- Wait counters, one each for md and fp, 4 bits: increment saturating at MAX_WAIT when the unit is valid and not granted; clear to 0 when it is granted or not valid.
- Write stage, latency 1: on a grant at cycle N, wb_wn=rd, wb_d=d, and wb_we=(rd!=0) are registered and appear during cycle N+1. The regfile captures them at the end of cycle N+1. With no grant, wb_we=0 at N+1, and wb_wn/wb_d hold their previous values.
- Scoreboard busy[31:1]:
  - Set on issue_valid && issue_ok && issue_rd!=0.
  - Cleared when an md or fp grant is registered into the write stage, i.e. the same edge that loads wb_*.
  - ALU grants never clear busy.
  - If a set and a clear hit the same register on the same edge, the set wins.
- hazard_a and hazard_b are combinational from the registered busy bits. No bypass: a register being cleared this cycle still reports hazard.
- issue_valid while issue_ok==0 is ignored; busy is unchanged. Issuing to rd==0 is always ok and is not tracked.
- A grant for rd==0 is accepted and consumed but produces wb_we=0.
- Reset, on clr high at an edge: busy=0, both counters=0, rr=0, wb_we=0, wb_wn=0, wb_d=0. All ready outputs are 0 while clr is high. In-flight results are discarded, and execute units are reset by the same clr.

Decomposition:
- Shared package: request index constants REQ_ALU=0, REQ_MD=1, REQ_FP=2; the X0 register constant; the 4-bit wait-counter width.
- One sub-module, wb_busy_board: the busy vector with set/clear, its two hazard lookups and issue_ok. The arbiter core, counters and write-stage registers stay in the top level.

Test Plan:
- clr high for 2 cycles with all valids high -> all ready=0, wb_we=0, wb_wn=0, wb_d=0, hazard_a=hazard_b=0.
- ALU only, alu_rd=5, alu_d=0xDEADBEEF -> alu_ready=1 at N; at N+1 wb_we=1, wb_wn=5, wb_d=0xDEADBEEF.
- md and fp both valid, ALU idle, rr=0 -> md granted at N, fp at N+1; wb_wn sequence md_rd then fp_rd on consecutive cycles.
- ALU valid every cycle with md valid and MAX_WAIT=4 -> md denied 4 cycles, granted on the 5th; alu_ready=0 on that cycle only.
- issue_rd=7 then rna=7 -> hazard_a=1 and issue_ok=0 for a second issue to rd 7. After md writes rd 7, hazard_a=0 the cycle after wb_we=1.
- md write to rd 9 on the same edge as a new issue to rd 9 -> busy[9] stays 1. Also alu_rd=0 grant -> wb_we=0.
